// File: rtl/float_converter.sv
// Converts a 12-bit two's-complement integer to an 8-bit float code (sign, 3-bit exponent, 4-bit significand).
// Latency: 1 cycle from in_valid to out_valid.
// Backpressure: none; accepts one sample per cycle.
module float_converter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [11:0] D_in,
    output logic        out_valid,
    output logic        S,
    output logic [2:0]  E,
    output logic [3:0]  F
);

    logic [11:0] mag;
    logic [3:0]  msb;
    logic [2:0]  e0;
    logic [12:0] shifted;
    logic [3:0]  f0;
    logic        rnd;
    logic [2:0]  e_nxt;
    logic [3:0]  f_nxt;

    always_comb begin
        mag = D_in[11] ? (~D_in + 12'd1) : D_in;

        msb = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (mag[i]) msb = 4'(i);
        end

        e0 = (msb >= 4'd4) ? 3'(msb - 4'd3) : 3'd0;

        // Appending one bit below the LSB makes the rounding bit fall out of the same shift;
        // for e0 = 0 it is that appended zero, so small values stay exact.
        shifted = {mag, 1'b0} >> e0;
        f0      = shifted[4:1];
        rnd     = shifted[0];

        e_nxt = e0;
        f_nxt = f0;
        if (D_in == 12'h800) begin
            e_nxt = 3'd7;
            f_nxt = 4'd15;
        end else if (rnd) begin
            if (f0 != 4'd15) begin
                f_nxt = f0 + 4'd1;
            end else if (e0 != 3'd7) begin
                f_nxt = 4'd8;
                e_nxt = e0 + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            S         <= 1'b0;
            E         <= 3'd0;
            F         <= 4'd0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S <= D_in[11];
                E <= e_nxt;
                F <= f_nxt;
            end
        end
    end

endmodule

// File: tb/tb_float_converter.sv
// Directed-vector bench for float_converter with a queue-based scoreboard and cycle-accurate latency check.
module tb_float_converter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] D_in;
    logic        out_valid;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;

    float_converter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .D_in      (D_in),
        .out_valid (out_valid),
        .S         (S),
        .E         (E),
        .F         (F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] din;
        logic [7:0]  sef;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_vec    = 0;
    int   n_bad    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    localparam int NV = 20;
    // {S, E[2:0], F[3:0]} computed by hand from the conversion rules
    logic [11:0] vin  [NV] = '{12'h000, 12'h0F0, 12'h078, 12'h02C, 12'h02D,
                               12'h02E, 12'h02F, 12'h03E, 12'h8F0, 12'hFFF,
                               12'h800, 12'h7C0, 12'h7FF, 12'h010, 12'h01F,
                               12'h00F, 12'hFF0, 12'h7BF, 12'h400, 12'hFC2};
    logic [7:0]  vexp [NV] = '{8'h00,   8'h4F,   8'h3F,   8'h2B,   8'h2B,
                               8'h2C,   8'h2C,   8'h38,   8'hFE,   8'h81,
                               8'hFF,   8'h7F,   8'h7F,   8'h18,   8'h28,
                               8'h0F,   8'h98,   8'h7F,   8'h78,   8'hB8};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; the next edge captures them.
    task automatic send(input logic [11:0] d, input logic [7:0] e);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        D_in     = d;
        q.push_back('{din: d, sef: e, cyc: cyc + 1});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        D_in     = 12'h5A5;
    endtask

    // Monitor: pops an expectation whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_out: got out_valid=1 with %h, expected no result", {S, E, F});
            end else begin
                exp_t x;
                x = q.pop_front();
                chk($sformatf("conv_%h", x.din), {S, E, F}, x.sef);
                n_vec++;
                if (cyc != x.cyc) begin
                    n_bad++;
                    $display("FAIL latency_%h: got cycle %0d, expected cycle %0d", x.din, cyc, x.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        D_in     = 12'h000;
        #23;
        chk("reset_sef", {S, E, F}, 8'h00);
        chk("reset_vld", {7'd0, out_valid}, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_sef", {S, E, F}, 8'h00);
        chk("post_reset_vld", {7'd0, out_valid}, 8'h00);

        for (int i = 0; i < NV; i++) send(vin[i], vexp[i]);
        idle();
        // Last result was captured on the edge just passed; the one after must drop valid and hold data.
        @(posedge clk);
        #1;
        chk("hold_vld", {7'd0, out_valid}, 8'h00);
        chk("hold_sef", {S, E, F}, vexp[NV-1]);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_sef_2", {S, E, F}, vexp[NV-1]);

        // Gapped stream: valid pulses separated by idle cycles.
        send(12'h0F0, 8'h4F);
        idle();
        send(12'hFFF, 8'h81);
        idle();
        idle();

        // Mid-stream reset: the pending sample must be discarded and outputs cleared at once.
        send(12'h7FF, 8'h7F);
        send(12'h8F0, 8'hFE);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        D_in     = 12'h02E;
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_clr_sef", {S, E, F}, 8'h00);
        chk("async_clr_vld", {7'd0, out_valid}, 8'h00);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_rst_sef", {S, E, F}, 8'h00);
        chk("after_rst_vld", {7'd0, out_valid}, 8'h00);

        send(12'h03E, 8'h38);
        send(12'h800, 8'hFF);
        idle();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d outstanding results, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
